// File: rtl/wallace_acc_pkg.sv
// Shared types and constants for the Wallace product accumulator.
package wallace_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int PROD_W = 16;

    // Counter width able to hold 0..len inclusive.
    function automatic int count_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/wallace_acc_ripple_adder.sv
// Ripple-carry adder built from single-bit full-adder cells.
// The carry-out tells the accumulator that the true sum overflowed W bits.

module one_bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module wallace_acc_ripple_adder #(
    parameter int W = 19
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry_out
);

    logic [W:0] carry;

    assign carry[0]  = 1'b0;
    assign carry_out = carry[W];

    for (genvar i = 0; i < W; i++) begin : g_bit
        one_bit_full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/eight_bit_wallace_product_accumulator.sv
// Accumulates ACC_LEN 16-bit products per frame into a saturating ACC_W-bit
// total, handed downstream over a valid/ready port.
// Optional build macro APPROX_ACC_TRUNC_EN zeroes the TRUNC_BITS product LSBs
// before accumulation (approximate accumulation).

module eight_bit_wallace_product_accumulator
    import wallace_acc_pkg::*;
#(
    parameter int ACC_LEN    = 8,
    parameter int ACC_W      = 19,
    parameter int TRUNC_BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf
);

    localparam int CNT_W = count_width(ACC_LEN);

`ifdef APPROX_ACC_TRUNC_EN
    localparam bit TRUNC_EN = 1'b1;
`else
    localparam bit TRUNC_EN = 1'b0;
`endif

    // Exact build keeps every product bit; truncating build clears the LSBs.
    localparam logic [PROD_W-1:0] TRUNC_MASK =
        TRUNC_EN ? ({PROD_W{1'b1}} << TRUNC_BITS) : {PROD_W{1'b1}};

    acc_state_t        state;
    logic [CNT_W-1:0]  count;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  addend;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  sat_sum;
    logic              carry_out;
    logic [PROD_W-1:0] prod_eff;
    logic              accept;
    logic              last_beat;

    assign prod_eff  = product_in & TRUNC_MASK;
    assign addend    = ACC_W'(prod_eff);
    assign accept    = in_valid & in_ready & (state == ACCUM);
    assign last_beat = (count == CNT_W'(ACC_LEN - 1));
    assign acc_out   = acc;

    wallace_acc_ripple_adder #(
        .W (ACC_W)
    ) u_adder (
        .a         (acc),
        .b         (addend),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // Clamp to all-ones when the adder overflows the accumulator width.
    always_comb begin
        sat_sum = sum;
        if (carry_out) begin
            sat_sum = '1;
        end
    end

    // Frame FSM: accumulate products, then hold the total until taken.
    // in_ready/out_valid are registered from the next state so they track it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    if (accept) begin
                        acc   <= sat_sum;
                        count <= count + 1'b1;
                        if (carry_out) begin
                            ovf <= 1'b1;
                        end
                        if (last_beat) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eight_bit_wallace_product_accumulator.sv
// Bench for the Wallace product accumulator: default instance plus a narrow
// (ACC_W = 16, ACC_LEN = 2) instance for saturation.
module tb_eight_bit_wallace_product_accumulator;

    localparam int TB_TRUNC = 4;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] product_in;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] acc_out;
    logic        ovf;

    logic        s_clr;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_product_in;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_acc_out;
    logic        s_ovf;

    int checks = 0;
    int errors = 0;
    longint frame_q[$];

    eight_bit_wallace_product_accumulator #(
        .ACC_LEN    (8),
        .ACC_W      (19),
        .TRUNC_BITS (TB_TRUNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .product_in (product_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_out    (acc_out),
        .ovf        (ovf)
    );

    eight_bit_wallace_product_accumulator #(
        .ACC_LEN    (2),
        .ACC_W      (16),
        .TRUNC_BITS (TB_TRUNC)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (s_clr),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .product_in (s_product_in),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .acc_out    (s_acc_out),
        .ovf        (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value a product contributes to the sum.
    function automatic longint model_p(input longint p);
`ifdef APPROX_ACC_TRUNC_EN
        return (p >> TB_TRUNC) << TB_TRUNC;
`else
        return p;
`endif
    endfunction

    // Reference: frame total clamped to the accumulator range.
    function automatic longint model_sum(input longint ps[$], input int w, output bit sat);
        longint total = 0;
        longint maxv  = (longint'(1) << w) - 1;
        foreach (ps[i]) total += model_p(ps[i]);
        sat = (total > maxv);
        return sat ? maxv : total;
    endfunction

    task automatic send_beat(input logic [15:0] p);
        bit got;
        bit done = 1'b0;
        in_valid   = 1'b1;
        product_in = p;
        for (int k = 0; k < 50 && !done; k++) begin
            got = in_ready;
            @(posedge clk); #1;
            done = got;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_beat: in_ready got 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic s_send(input logic [15:0] p);
        bit got;
        bit done = 1'b0;
        s_in_valid   = 1'b1;
        s_product_in = p;
        for (int k = 0; k < 50 && !done; k++) begin
            got = s_in_ready;
            @(posedge clk); #1;
            done = got;
        end
        s_in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL s_send: s_in_ready got 0 expected 1 within 50 cycles");
        end
    endtask

    // Sends frame_q, checks the result, holds for hold_delay cycles, then
    // completes the output handshake.
    task automatic run_frame(input string name, input int max_gap, input int hold_delay,
                             input bit offer_in_hold);
        longint     exp;
        bit         exp_ovf;
        logic [18:0] exp19;
        exp   = model_sum(frame_q, 19, exp_ovf);
        exp19 = 19'(exp);
        foreach (frame_q[i]) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (i == frame_q.size() - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_out_valid: got %b expected 0", name, out_valid);
                end
            end
            send_beat(16'(frame_q[i]));
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s hold_flags: got out_valid=%b in_ready=%b expected 1/0", name, out_valid, in_ready);
        end
        checks++;
        if (acc_out !== exp19 || ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s sum: got %0d ovf=%b expected %0d ovf=%b", name, acc_out, ovf, exp19, exp_ovf);
        end
        for (int c = 0; c < hold_delay; c++) begin
            if (offer_in_hold) begin
                in_valid   = 1'b1;
                product_in = 16'($urandom_range(1, 65535));
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== exp19 || ovf !== exp_ovf) begin
                errors++;
                $display("FAIL %s hold_stable: got v=%b r=%b acc=%0d ovf=%b expected 1/0/%0d/%b",
                         name, out_valid, in_ready, acc_out, ovf, exp19, exp_ovf);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_handshake: got out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || acc_out !== 19'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b acc=%0d ovf=%b expected 0/0/0", out_valid, acc_out, ovf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, s_in_ready);
        end
    endtask

    task automatic test_exact();
        frame_q = {};
        repeat (8) frame_q.push_back(65025);
        run_frame("exact_max", 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        frame_q = {};
        repeat (8) frame_q.push_back(longint'($urandom_range(0, 65535)));
        run_frame("backpressure", 0, 5, 1'b1);
        // Products offered during HOLD must not leak into this frame.
        frame_q = {};
        repeat (8) frame_q.push_back(longint'($urandom_range(0, 65535)));
        run_frame("after_backpressure", 1, 1, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            frame_q = {};
            repeat (8) frame_q.push_back(longint'($urandom_range(0, 65535)));
            run_frame("random_frame", 2, int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_clr();
        repeat (3) send_beat(16'($urandom_range(1, 65535)));
        clr        = 1'b1;
        in_valid   = 1'b1;
        product_in = 16'hFFFF;
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (acc_out !== 19'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_accum: got acc=%0d v=%b r=%b ovf=%b expected 0/0/1/0", acc_out, out_valid, in_ready, ovf);
        end
        frame_q = {};
        repeat (8) frame_q.push_back(1);
        run_frame("clr_ones", 0, 0, 1'b0);
        // clr while a frame sits in HOLD discards it, even with out_ready high.
        repeat (8) send_beat(16'($urandom_range(1, 65535)));
        in_valid  = 1'b0;
        clr       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clr       = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (acc_out !== 19'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_hold: got acc=%0d v=%b r=%b expected 0/0/1", acc_out, out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        repeat (4) send_beat(16'($urandom_range(1, 65535)));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (acc_out !== 19'd0 || out_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got acc=%0d v=%b ovf=%b expected 0/0/0", acc_out, out_valid, ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame_q = {};
        repeat (8) frame_q.push_back(longint'($urandom_range(0, 65535)));
        run_frame("post_reset_frame", 1, 0, 1'b0);
    endtask

    task automatic test_saturation();
        longint      exp;
        bit          exp_ovf;
        longint      vals[3][2];
        vals[0][0] = 40000; vals[0][1] = 40000;
        vals[1][0] = 1;     vals[1][1] = 2;
        vals[2][0] = longint'($urandom_range(0, 65535));
        vals[2][1] = longint'($urandom_range(0, 65535));
        for (int f = 0; f < 3; f++) begin
            frame_q = {};
            frame_q.push_back(vals[f][0]);
            frame_q.push_back(vals[f][1]);
            exp = model_sum(frame_q, 16, exp_ovf);
            s_send(16'(vals[f][0]));
            s_send(16'(vals[f][1]));
            checks++;
            if (s_out_valid !== 1'b1 || s_acc_out !== 16'(exp) || s_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL sat_frame%0d: got v=%b acc=%0d ovf=%b expected 1/%0d/%b",
                         f, s_out_valid, s_acc_out, s_ovf, exp, exp_ovf);
            end
            s_out_ready = 1'b1;
            @(posedge clk); #1;
            s_out_ready = 1'b0;
            checks++;
            if (s_out_valid !== 1'b0 || s_ovf !== 1'b0 || s_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sat_release%0d: got v=%b ovf=%b r=%b expected 0/0/1", f, s_out_valid, s_ovf, s_in_ready);
            end
        end
    endtask

    task automatic test_trunc();
        frame_q = {};
        repeat (8) frame_q.push_back(255);
        run_frame("trunc_ff", 0, 0, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        clr          = 1'b0;
        in_valid     = 1'b0;
        product_in   = '0;
        out_ready    = 1'b0;
        s_clr        = 1'b0;
        s_in_valid   = 1'b0;
        s_product_in = '0;
        s_out_ready  = 1'b0;

        test_reset();
        test_exact();
        test_backpressure();
        test_random_frames();
        test_clr();
        test_async_reset();
        test_saturation();
        test_trunc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
